// File: rtl/bomberman_pkg.sv
// Shared types and constants for the player movement sequencer.
package bomberman_pkg;

  typedef enum logic [1:0] {
    DOWN  = 2'd0,
    UP    = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int TILE_SZ = 32;
  localparam int TILE_SH = 5;

  // Default playfield bounds (inclusive, sprite top-left).
  localparam int SCR_X_MIN = 32;
  localparam int SCR_X_MAX = 736;
  localparam int SCR_Y_MIN = 32;
  localparam int SCR_Y_MAX = 536;

  localparam int COORD_W = 10;
  localparam int TILE_W  = 5;
  // Signed working width for target math; wide enough that pos +/- STEP never wraps.
  localparam int CALC_W  = 12;

  // Pixel coordinate to tile index.
  function automatic logic [TILE_W-1:0] tile_of(input logic [CALC_W-1:0] px);
    return TILE_W'(px >> TILE_SH);
  endfunction

  // True when a coordinate sits exactly on a tile boundary (corridor aligned).
  function automatic logic is_aligned(input logic [COORD_W-1:0] px);
    return (int'(px) % TILE_SZ) == 0;
  endfunction

endpackage

// File: rtl/player_anim.sv
// Walk-cycle generator: counts accepted moves and flips the walk bit every ANIM_DIV moves.
module player_anim
  import bomberman_pkg::*;
#(
  parameter int ANIM_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic walk
);

  localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic [CNT_W-1:0] count;

  // Move counter with wrap; the walk bit toggles on each wrap, clr only drops the walk bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      walk  <= 1'b0;
    end else if (clr) begin
      walk <= 1'b0;
    end else if (inc) begin
      if (count == CNT_W'(ANIM_DIV - 1)) begin
        count <= '0;
        walk  <= ~walk;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/player_ctrl.sv
// Per-frame player movement sequencer: samples buttons on frame_tick, queries the map for the
// destination tile, then commits the new position and sprite selection.
module player_ctrl
  import bomberman_pkg::*;
#(
  parameter int START_X  = 64,
  parameter int START_Y  = 64,
  parameter int STEP     = 2,
  parameter int X_MIN    = SCR_X_MIN,
  parameter int X_MAX    = SCR_X_MAX,
  parameter int Y_MIN    = SCR_Y_MIN,
  parameter int Y_MAX    = SCR_Y_MAX,
  parameter int ANIM_DIV = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               alive,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  output logic               wall_req,
  output logic [TILE_W-1:0]  wall_tx,
  output logic [TILE_W-1:0]  wall_ty,
  input  logic               wall_ack,
  input  logic               wall_blocked,
  output logic [COORD_W-1:0] playerX,
  output logic [COORD_W-1:0] playerY,
  output logic [2:0]         sprite_num,
  output logic               moving
);

  localparam logic signed [CALC_W-1:0] STEP_S  = CALC_W'(STEP);
  localparam logic signed [CALC_W-1:0] X_MIN_S = CALC_W'(X_MIN);
  localparam logic signed [CALC_W-1:0] X_MAX_S = CALC_W'(X_MAX);
  localparam logic signed [CALC_W-1:0] Y_MIN_S = CALC_W'(Y_MIN);
  localparam logic signed [CALC_W-1:0] Y_MAX_S = CALC_W'(Y_MAX);

  state_t                    state;
  dir_t                      dir_q;
  logic [COORD_W-1:0]        tgt_x;
  logic [COORD_W-1:0]        tgt_y;
  logic                      walk;

  dir_t                      pick;
  logic                      btn_any;
  logic signed [CALC_W-1:0]  nxt_x;
  logic signed [CALC_W-1:0]  nxt_y;
  logic                      legal;
  logic [CALC_W-1:0]         lead_x;
  logic [CALC_W-1:0]         lead_y;
  logic                      tick_go;
  logic                      anim_clr;
  logic                      anim_inc;

  assign tick_go    = (state == IDLE) && frame_tick && alive;
  assign anim_clr   = tick_go && !btn_any;
  assign anim_inc   = (state == WAIT) && wall_ack && !wall_blocked && alive;
  assign sprite_num = {dir_q, walk};

  // Direction priority and candidate target with bounds and corridor-alignment screening.
  always_comb begin
    btn_any = btn_up | btn_down | btn_left | btn_right;
    if (btn_up)        pick = UP;
    else if (btn_down) pick = DOWN;
    else if (btn_left) pick = LEFT;
    else               pick = RIGHT;

    nxt_x = $signed({2'b00, playerX});
    nxt_y = $signed({2'b00, playerY});
    case (pick)
      UP:    nxt_y = nxt_y - STEP_S;
      DOWN:  nxt_y = nxt_y + STEP_S;
      LEFT:  nxt_x = nxt_x - STEP_S;
      RIGHT: nxt_x = nxt_x + STEP_S;
      default: ;
    endcase

    legal = (nxt_x >= X_MIN_S) && (nxt_x <= X_MAX_S) &&
            (nxt_y >= Y_MIN_S) && (nxt_y <= Y_MAX_S) &&
            ((pick == UP || pick == DOWN) ? is_aligned(playerX) : is_aligned(playerY));
  end

  // Leading edge of the sprite in the direction of travel picks the tile to query.
  always_comb begin
    lead_x = {2'b00, tgt_x};
    lead_y = {2'b00, tgt_y};
    if (dir_q == RIGHT) lead_x = lead_x + CALC_W'(TILE_SZ - 1);
    if (dir_q == DOWN)  lead_y = lead_y + CALC_W'(TILE_SZ - 1);
  end

  // Sequencer: IDLE screens the request, CHECK latches the tile, WAIT runs the map handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      dir_q    <= DOWN;
      tgt_x    <= COORD_W'(START_X);
      tgt_y    <= COORD_W'(START_Y);
      playerX  <= COORD_W'(START_X);
      playerY  <= COORD_W'(START_Y);
      wall_req <= 1'b0;
      wall_tx  <= '0;
      wall_ty  <= '0;
      moving   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tick_go) begin
            if (!btn_any) begin
              moving <= 1'b0;
            end else begin
              dir_q <= pick;
              if (legal) begin
                tgt_x <= nxt_x[COORD_W-1:0];
                tgt_y <= nxt_y[COORD_W-1:0];
                state <= CHECK;
              end else begin
                moving <= 1'b0;
              end
            end
          end
        end
        CHECK: begin
          wall_tx  <= tile_of(lead_x);
          wall_ty  <= tile_of(lead_y);
          wall_req <= 1'b1;
          state    <= WAIT;
        end
        WAIT: begin
          if (wall_ack) begin
            wall_req <= 1'b0;
            state    <= IDLE;
            if (!wall_blocked && alive) begin
              playerX <= tgt_x;
              playerY <= tgt_y;
              moving  <= 1'b1;
            end else begin
              moving <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  player_anim #(.ANIM_DIV(ANIM_DIV)) u_anim (
    .clk   (clk),
    .reset (reset),
    .clr   (anim_clr),
    .inc   (anim_inc),
    .walk  (walk)
  );

endmodule

// File: tb/tb_player_ctrl.sv
// Bench for player_ctrl: frame-level behavioural model checked every cycle, plus directed scenarios
// with hand-computed expectations.
module tb_player_ctrl;

  localparam int STEP = 2;
  localparam int ANIM_DIV = 4;
  localparam int X_MIN = 32, X_MAX = 736, Y_MIN = 32, Y_MAX = 536;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic frame_tick = 1'b0, alive = 1'b1;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic wall_ack = 1'b0, wall_blocked = 1'b0;
  logic wall_req, moving;
  logic [4:0] wall_tx, wall_ty;
  logic [9:0] playerX, playerY;
  logic [2:0] sprite_num;

  int n_cmp = 0;
  int n_bad = 0;

  player_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .alive(alive),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .wall_req(wall_req), .wall_tx(wall_tx), .wall_ty(wall_ty),
    .wall_ack(wall_ack), .wall_blocked(wall_blocked),
    .playerX(playerX), .playerY(playerY), .sprite_num(sprite_num), .moving(moving)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_x, m_y, m_dir, m_walk, m_moves, m_moving;
  int m_busy, m_req, m_tx, m_ty, m_tgx, m_tgy;

  always @(posedge clk or posedge reset) begin : model
    int dx, dy, d;
    bit ok;
    if (reset) begin
      m_x = 64; m_y = 64; m_dir = 0; m_walk = 0; m_moves = 0; m_moving = 0;
      m_busy = 0; m_req = 0; m_tx = 0; m_ty = 0; m_tgx = 64; m_tgy = 64;
    end else if (m_req != 0) begin
      if (wall_ack) begin
        m_req = 0; m_busy = 0;
        if (!wall_blocked && alive) begin
          m_x = m_tgx; m_y = m_tgy; m_moving = 1; m_moves++;
          if (m_moves % ANIM_DIV == 0) m_walk = 1 - m_walk;
        end else begin
          m_moving = 0;
        end
      end
    end else if (m_busy != 0) begin
      m_req = 1;
      m_tx = (m_tgx > m_x) ? (m_tgx + 31) / 32 : m_tgx / 32;
      m_ty = (m_tgy > m_y) ? (m_tgy + 31) / 32 : m_tgy / 32;
    end else if (frame_tick && alive) begin
      dx = 0; dy = 0; d = -1;
      if (btn_up)         begin dy = -STEP; d = 1; end
      else if (btn_down)  begin dy =  STEP; d = 0; end
      else if (btn_left)  begin dx = -STEP; d = 2; end
      else if (btn_right) begin dx =  STEP; d = 3; end
      if (d < 0) begin
        m_moving = 0; m_walk = 0;
      end else begin
        m_dir = d;
        m_tgx = m_x + dx; m_tgy = m_y + dy;
        ok = (m_tgx >= X_MIN) && (m_tgx <= X_MAX) && (m_tgy >= Y_MIN) && (m_tgy <= Y_MAX) &&
             ((dx != 0) ? (m_y % 32 == 0) : (m_x % 32 == 0));
        if (ok) m_busy = 1;
        else m_moving = 0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("playerX", int'(playerX), m_x);
    chk("playerY", int'(playerY), m_y);
    chk("sprite_num", int'(sprite_num), m_dir * 2 + m_walk);
    chk("moving", int'(moving), m_moving);
    chk("wall_req", int'(wall_req), m_req);
    if (m_req != 0) begin
      chk("wall_tx", int'(wall_tx), m_tx);
      chk("wall_ty", int'(wall_ty), m_ty);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // b = {up, down, left, right}
  task automatic tick(input logic [3:0] b);
    {btn_up, btn_down, btn_left, btn_right} = b;
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  task automatic move(input logic [3:0] b, input logic blk, input int dly);
    bit seen;
    tick(b);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step(1);
      seen = wall_req;
    end
    chk("req_rise", int'(wall_req), 1);
    if (seen) begin
      step(dly);
      wall_blocked = blk;
      wall_ack = 1'b1;
      step(1);
      wall_ack = 1'b0;
      wall_blocked = 1'b0;
    end
    step(1);
  endtask

  task automatic no_move(input logic [3:0] b);
    bit seen;
    tick(b);
    seen = 1'b0;
    repeat (4) begin
      step(1);
      if (wall_req) seen = 1'b1;
    end
    chk("no_req", int'(seen), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    bit held_ok;
    logic [4:0] tx0, ty0;
    #2 reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);

    // Reset state
    chk("rst_x", int'(playerX), 64);
    chk("rst_y", int'(playerY), 64);
    chk("rst_sprite", int'(sprite_num), 0);
    chk("rst_moving", int'(moving), 0);
    chk("rst_req", int'(wall_req), 0);
    chk("rst_tx", int'(wall_tx), 0);
    chk("rst_ty", int'(wall_ty), 0);

    // One free move right with latency checks
    tick(4'b0001);
    chk("B_req_cyc1", int'(wall_req), 0);
    step(1);
    chk("B_req_cyc2", int'(wall_req), 1);
    chk("B_tx", int'(wall_tx), 3);
    chk("B_ty", int'(wall_ty), 2);
    wall_ack = 1'b1;
    step(1);
    wall_ack = 1'b0;
    chk("B_x", int'(playerX), 66);
    chk("B_sprite", int'(sprite_num), 6);
    chk("B_moving", int'(moving), 1);
    chk("B_req_drop", int'(wall_req), 0);

    // Unaligned Y blocks a horizontal move
    do_reset();
    repeat (3) move(4'b0100, 1'b0, 0);
    chk("C_y", int'(playerY), 70);
    no_move(4'b0010);
    chk("C_x", int'(playerX), 64);
    chk("C_y2", int'(playerY), 70);
    chk("C_dir", int'(sprite_num[2:1]), 2);
    chk("C_moving", int'(moving), 0);

    // Priority: up beats down, left beats right
    do_reset();
    move(4'b1100, 1'b0, 0);
    chk("P_ud_y", int'(playerY), 62);
    chk("P_ud_sprite", int'(sprite_num), 2);
    do_reset();
    move(4'b0011, 1'b0, 0);
    chk("P_lr_x", int'(playerX), 62);
    chk("P_lr_sprite", int'(sprite_num), 4);

    // Blocked down move with 20-cycle ack delay and a dropped tick during WAIT
    do_reset();
    tick(4'b0100);
    step(1);
    chk("D_req", int'(wall_req), 1);
    chk("D_tx", int'(wall_tx), 2);
    chk("D_ty", int'(wall_ty), 3);
    tx0 = wall_tx;
    ty0 = wall_ty;
    held_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin frame_tick = 1'b1; btn_right = 1'b1; end
      if (i == 11) begin frame_tick = 1'b0; btn_right = 1'b0; end
      step(1);
      if (!wall_req || wall_tx != tx0 || wall_ty != ty0) held_ok = 1'b0;
    end
    chk("D_held", int'(held_ok), 1);
    wall_blocked = 1'b1;
    wall_ack = 1'b1;
    step(1);
    wall_ack = 1'b0;
    wall_blocked = 1'b0;
    chk("D_y", int'(playerY), 64);
    chk("D_x", int'(playerX), 64);
    chk("D_moving", int'(moving), 0);
    chk("D_sprite", int'(sprite_num), 0);
    step(4);
    chk("D_dropped", int'(wall_req), 0);

    // Walk animation over 12 free moves right
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      move(4'b0001, 1'b0, 0);
      chk("E_x", int'(playerX), 64 + 2 * i);
      chk("E_sprite", int'(sprite_num), 6 + ((i / 4) % 2));
    end
    chk("E_x8", int'(playerX), 88);

    // alive=0 ignores the tick; alive dropping in WAIT suppresses the move
    alive = 1'b0;
    no_move(4'b0001);
    chk("A_x_frozen", int'(playerX), 88);
    chk("A_moving_kept", int'(moving), 1);
    alive = 1'b1;
    tick(4'b0001);
    step(1);
    alive = 1'b0;
    wall_ack = 1'b1;
    step(1);
    wall_ack = 1'b0;
    alive = 1'b1;
    chk("A_x", int'(playerX), 88);
    chk("A_moving", int'(moving), 0);
    chk("A_sprite", int'(sprite_num), 7);

    // Release clears the walk bit
    tick(4'b0000);
    chk("E_rel_sprite", int'(sprite_num), 6);
    chk("E_rel_moving", int'(moving), 0);

    // Walk to the right bound; exactly X_MAX is accepted, beyond is rejected
    do_reset();
    repeat ((736 - 64) / 2) move(4'b0001, 1'b0, 0);
    chk("F_x", int'(playerX), 736);
    chk("F_moving", int'(moving), 1);
    no_move(4'b0001);
    chk("F_x2", int'(playerX), 736);
    chk("F_moving2", int'(moving), 0);

    // Reset during WAIT drops the request immediately; a late ack is ignored
    do_reset();
    tick(4'b0001);
    step(1);
    chk("G_req_pre", int'(wall_req), 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("G_req", int'(wall_req), 0);
    chk("G_x", int'(playerX), 64);
    chk("G_y", int'(playerY), 64);
    @(posedge clk);
    #1;
    step(1);
    reset = 1'b0;
    step(1);
    wall_ack = 1'b1;
    step(1);
    wall_ack = 1'b0;
    step(2);
    chk("G_late_req", int'(wall_req), 0);
    chk("G_late_x", int'(playerX), 64);
    chk("G_late_moving", int'(moving), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
